// File: rtl/cplx_gram_engine.sv
// cplx_gram_engine: streaming complex Gram engine, R = A * B^H.
// Loads A and B (N_ROW x N_COL) over valid/ready, runs a 4-stage MAC
// pipeline, then streams the N_ROW x N_ROW result with backpressure.
// Optional macro GRAM_BB_EN adds a second MAC chain computing B * B^H.

module cplx_gram_engine_mac #(
    parameter int DW    = 32,
    parameter int IW    = 4,
    parameter int ACC_W = 72,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld_i,
    input  logic                 first_i,
    input  logic                 last_i,
    input  logic [IW-1:0]        idx_i,
    input  logic signed [DW-1:0] x_re_i,
    input  logic signed [DW-1:0] x_im_i,
    input  logic signed [DW-1:0] y_re_i,
    input  logic signed [DW-1:0] y_im_i,
    output logic                 wr_o,
    output logic [IW-1:0]        wr_idx_o,
    output logic signed [DW-1:0] wr_re_o,
    output logic signed [DW-1:0] wr_im_o
);
    localparam int PW = 2 * DW;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    logic                    vld_q, first_q, last_q;
    logic [IW-1:0]           idx_q;
    logic signed [PW-1:0]    p_rr_q, p_ii_q, p_ir_q, p_ri_q;
    logic signed [ACC_W-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d, sh_re, sh_im;

    function automatic logic signed [DW-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > MAXV) return MAXV[DW-1:0];
        if (v < MINV) return MINV[DW-1:0];
        return v[DW-1:0];
    endfunction

    // multiply stage: four full-width partial products of x * conj(y)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            p_rr_q  <= '0;
            p_ii_q  <= '0;
            p_ir_q  <= '0;
            p_ri_q  <= '0;
        end else begin
            vld_q   <= vld_i;
            first_q <= first_i;
            last_q  <= last_i;
            idx_q   <= idx_i;
            p_rr_q  <= PW'(x_re_i) * PW'(y_re_i);
            p_ii_q  <= PW'(x_im_i) * PW'(y_im_i);
            p_ir_q  <= PW'(x_im_i) * PW'(y_re_i);
            p_ri_q  <= PW'(x_re_i) * PW'(y_im_i);
        end
    end

    // accumulate: restart on the first column of each (r,c), then scale
    always_comb begin
        acc_re_d = first_q ? '0 : acc_re_q;
        acc_im_d = first_q ? '0 : acc_im_q;
        acc_re_d = acc_re_d + ACC_W'(p_rr_q) + ACC_W'(p_ii_q);
        acc_im_d = acc_im_d + ACC_W'(p_ir_q) - ACC_W'(p_ri_q);
        sh_re    = acc_re_d >>> SHIFT;
        sh_im    = acc_im_d >>> SHIFT;
    end

    // accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else if (vld_q) begin
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
        end
    end

    // finished result is written straight from the accumulate stage
    assign wr_o     = vld_q & last_q;
    assign wr_idx_o = idx_q;
    assign wr_re_o  = sat(sh_re);
    assign wr_im_o  = sat(sh_im);
endmodule

module cplx_gram_engine #(
    parameter int DW    = 32,
    parameter int N_ROW = 4,
    parameter int N_COL = 64,
    parameter int SHIFT = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic signed [DW-1:0]                   in_a_re,
    input  logic signed [DW-1:0]                   in_a_im,
    input  logic signed [DW-1:0]                   in_b_re,
    input  logic signed [DW-1:0]                   in_b_im,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [DW-1:0]                   out_re,
    output logic signed [DW-1:0]                   out_im,
    output logic [$clog2((N_ROW > 1) ? N_ROW : 2)-1:0] out_row,
    output logic [$clog2((N_ROW > 1) ? N_ROW : 2)-1:0] out_col,
    output logic                                   out_sel,
    output logic                                   out_last,
    output logic                                   busy
);
    localparam int NR2   = N_ROW * N_ROW;
    localparam int NE    = N_ROW * N_COL;
    localparam int NI    = NR2 * N_COL;
    localparam int RW    = $clog2((N_ROW > 1) ? N_ROW : 2);
    localparam int KW    = $clog2((N_COL > 1) ? N_COL : 2);
    localparam int AW    = $clog2((NE > 1) ? NE : 2);
    localparam int IW    = $clog2((NR2 > 1) ? NR2 : 2);
    localparam int CW    = $clog2(NI + 3) + 1;
    localparam int ACC_W = 2 * DW + $clog2(N_COL) + 2;
`ifdef GRAM_BB_EN
    localparam bit FIRST_LAST = 1'b0;
`else
    localparam bit FIRST_LAST = (N_ROW == 1);
`endif

    typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;
    state_t state_q, state_d;

    logic signed [DW-1:0] mem_are [0:NE-1];
    logic signed [DW-1:0] mem_aim [0:NE-1];
    logic signed [DW-1:0] mem_bre [0:NE-1];
    logic signed [DW-1:0] mem_bim [0:NE-1];
    logic signed [DW-1:0] res_ab_re [0:NR2-1];
    logic signed [DW-1:0] res_ab_im [0:NR2-1];

    logic [AW-1:0] ld_cnt_q, a_addr, b_addr;
    logic [CW-1:0] cyc_q;
    logic [KW-1:0] k_q;
    logic [RW-1:0] r_q, c_q;
    logic          issue, in_fire, out_fire, ld_last;

    logic                 s1_vld_q, s1_first_q, s1_last_q;
    logic [IW-1:0]        s1_idx_q;
    logic signed [DW-1:0] s1_are_q, s1_aim_q, s1_bre_q, s1_bim_q;

    logic                 ab_wr;
    logic [IW-1:0]        ab_idx;
    logic signed [DW-1:0] ab_re, ab_im;

    logic                 out_valid_q, out_last_q;
    logic [RW-1:0]        out_r_q, out_c_q, nxt_r, nxt_c;
    logic [IW-1:0]        nxt_idx;
    logic                 nxt_last;
    logic signed [DW-1:0] out_re_q, out_im_q, nxt_re, nxt_im;

    // in_ready is held low for the whole reset assertion
    assign in_ready = (state_q == LOAD) && !rst;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;
    assign ld_last  = (ld_cnt_q == AW'(NE - 1));
    assign issue    = (state_q == COMPUTE) && (cyc_q < CW'(NI));
    assign busy     = (state_q != LOAD);
    assign a_addr   = AW'(r_q) * AW'(N_COL) + AW'(k_q);
    assign b_addr   = AW'(c_q) * AW'(N_COL) + AW'(k_q);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    // next state: COMPUTE covers N_COL*N_ROW^2 issues plus 3 drain cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_fire && ld_last) state_d = COMPUTE;
            COMPUTE: if (cyc_q == CW'(NI + 2)) state_d = OUT;
            OUT:     if (out_fire && out_last_q) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // load counter and (r,c,k) issue counters, k innermost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt_q <= '0;
            cyc_q    <= '0;
            k_q      <= '0;
            c_q      <= '0;
            r_q      <= '0;
        end else begin
            if (in_fire) ld_cnt_q <= ld_last ? '0 : ld_cnt_q + AW'(1);
            if (state_q != COMPUTE) begin
                cyc_q <= '0;
                k_q   <= '0;
                c_q   <= '0;
                r_q   <= '0;
            end else begin
                cyc_q <= cyc_q + CW'(1);
                if (issue) begin
                    if (k_q == KW'(N_COL - 1)) begin
                        k_q <= '0;
                        if (c_q == RW'(N_ROW - 1)) begin
                            c_q <= '0;
                            r_q <= r_q + RW'(1);
                        end else begin
                            c_q <= c_q + RW'(1);
                        end
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
            end
        end
    end

    // operand store, row-major r*N_COL+k
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_are[ld_cnt_q] <= in_a_re;
            mem_aim[ld_cnt_q] <= in_a_im;
            mem_bre[ld_cnt_q] <= in_b_re;
            mem_bim[ld_cnt_q] <= in_b_im;
        end
    end

    // read stage control: valid and per-element tags follow the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_idx_q   <= '0;
        end else begin
            s1_vld_q   <= issue;
            s1_first_q <= (k_q == '0);
            s1_last_q  <= (k_q == KW'(N_COL - 1));
            s1_idx_q   <= IW'(r_q) * IW'(N_ROW) + IW'(c_q);
        end
    end

`ifdef GRAM_BB_EN
    logic signed [DW-1:0] s1_brr_q, s1_bri_q;
    logic signed [DW-1:0] res_bb_re [0:NR2-1];
    logic signed [DW-1:0] res_bb_im [0:NR2-1];
    logic                 bb_wr;
    logic [IW-1:0]        bb_idx;
    logic signed [DW-1:0] bb_re, bb_im;
    logic                 out_sel_q, nxt_sel;
`endif

    // read stage data: A row r, B row c (and B row r for B*B^H)
    always_ff @(posedge clk) begin
        s1_are_q <= mem_are[a_addr];
        s1_aim_q <= mem_aim[a_addr];
        s1_bre_q <= mem_bre[b_addr];
        s1_bim_q <= mem_bim[b_addr];
`ifdef GRAM_BB_EN
        s1_brr_q <= mem_bre[a_addr];
        s1_bri_q <= mem_bim[a_addr];
`endif
    end

    cplx_gram_engine_mac #(.DW(DW), .IW(IW), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_mac_ab (
        .clk(clk), .rst(rst), .vld_i(s1_vld_q), .first_i(s1_first_q), .last_i(s1_last_q),
        .idx_i(s1_idx_q), .x_re_i(s1_are_q), .x_im_i(s1_aim_q), .y_re_i(s1_bre_q),
        .y_im_i(s1_bim_q), .wr_o(ab_wr), .wr_idx_o(ab_idx), .wr_re_o(ab_re), .wr_im_o(ab_im)
    );

`ifdef GRAM_BB_EN
    cplx_gram_engine_mac #(.DW(DW), .IW(IW), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_mac_bb (
        .clk(clk), .rst(rst), .vld_i(s1_vld_q), .first_i(s1_first_q), .last_i(s1_last_q),
        .idx_i(s1_idx_q), .x_re_i(s1_brr_q), .x_im_i(s1_bri_q), .y_re_i(s1_bre_q),
        .y_im_i(s1_bim_q), .wr_o(bb_wr), .wr_idx_o(bb_idx), .wr_re_o(bb_re), .wr_im_o(bb_im)
    );
`endif

    // result buffers
    always_ff @(posedge clk) begin
        if (ab_wr) begin
            res_ab_re[ab_idx] <= ab_re;
            res_ab_im[ab_idx] <= ab_im;
        end
`ifdef GRAM_BB_EN
        if (bb_wr) begin
            res_bb_re[bb_idx] <= bb_re;
            res_bb_im[bb_idx] <= bb_im;
        end
`endif
    end

    // next output beat: (r,c) row-major, A*B^H set before B*B^H set
    always_comb begin
        nxt_r = out_r_q;
        nxt_c = out_c_q + RW'(1);
`ifdef GRAM_BB_EN
        nxt_sel = out_sel_q;
`endif
        if (out_c_q == RW'(N_ROW - 1)) begin
            nxt_c = '0;
            nxt_r = out_r_q + RW'(1);
            if (out_r_q == RW'(N_ROW - 1)) begin
                nxt_r = '0;
`ifdef GRAM_BB_EN
                nxt_sel = 1'b1;
`endif
            end
        end
        nxt_idx = IW'(nxt_r) * IW'(N_ROW) + IW'(nxt_c);
        nxt_re  = res_ab_re[nxt_idx];
        nxt_im  = res_ab_im[nxt_idx];
        nxt_last = (nxt_r == RW'(N_ROW - 1)) && (nxt_c == RW'(N_ROW - 1));
`ifdef GRAM_BB_EN
        nxt_last = nxt_last && nxt_sel;
        if (nxt_sel) begin
            nxt_re = res_bb_re[nxt_idx];
            nxt_im = res_bb_im[nxt_idx];
        end
`endif
    end

    // output registers: only advance on a transfer, so stalls hold them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_r_q     <= '0;
            out_c_q     <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
`ifdef GRAM_BB_EN
            out_sel_q   <= 1'b0;
`endif
        end else if (state_q == COMPUTE && state_d == OUT) begin
            out_valid_q <= 1'b1;
            out_last_q  <= FIRST_LAST;
            out_r_q     <= '0;
            out_c_q     <= '0;
            out_re_q    <= res_ab_re[0];
            out_im_q    <= res_ab_im[0];
`ifdef GRAM_BB_EN
            out_sel_q   <= 1'b0;
`endif
        end else if (out_fire) begin
            if (out_last_q) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                out_r_q     <= '0;
                out_c_q     <= '0;
                out_re_q    <= '0;
                out_im_q    <= '0;
`ifdef GRAM_BB_EN
                out_sel_q   <= 1'b0;
`endif
            end else begin
                out_last_q  <= nxt_last;
                out_r_q     <= nxt_r;
                out_c_q     <= nxt_c;
                out_re_q    <= nxt_re;
                out_im_q    <= nxt_im;
`ifdef GRAM_BB_EN
                out_sel_q   <= nxt_sel;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_row   = out_r_q;
    assign out_col   = out_c_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
`ifdef GRAM_BB_EN
    assign out_sel   = out_sel_q;
`else
    assign out_sel   = 1'b0;
`endif
endmodule
